// File: rtl/mux_scan_seq_pkg.sv
// mux_scan_pkg: shared state encoding and default parameters for the mux scan sequencer
package mux_scan_pkg;
  localparam int NUM_CH_DEF = 10;
  localparam int DW_DEF = 8;
  localparam int SW_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, OUT = 2'd2} state_e;
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_SETTLE = SETTLE;
  localparam logic [1:0] S_OUT = OUT;
endpackage

// File: rtl/mux_scan_seq_if.sv
// mux_scan_seq_if: command, mux select/data and sample output bundle of the sequencer
interface mux_scan_seq_if import mux_scan_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
);
  logic start;
  logic [NUM_CH-1:0] ch_mask;
  logic [DW-1:0] mux_data;
  logic [SW-1:0] sel;
  logic out_valid;
  logic out_ready;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_chan;
  logic busy;
  logic done;
  modport master (
    input start, ch_mask, mux_data, out_ready,
    output sel, out_valid, out_data, out_chan, busy, done
  );
  modport slave (
    output start, ch_mask, mux_data, out_ready,
    input sel, out_valid, out_data, out_chan, busy, done
  );
endinterface

// File: rtl/mux_scan_seq_next_ch.sv
// mux_scan_next_ch: lowest set mask bit strictly above cur; cur = -1 searches from bit 0
module mux_scan_next_ch import mux_scan_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int SW = SW_DEF
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic signed [SW:0] cur,
  output logic [SW-1:0] nxt,
  output logic found
);
  // scan downward so the lowest qualifying bit is the last one written
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && i > int'(cur)) begin
        nxt = SW'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: sweeps enabled mux channels in ascending order, one registered sample per channel
module mux_scan_seq import mux_scan_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF
) (
  input logic clk,
  input logic rst,
  mux_scan_seq_if.master bus
);
  logic [1:0] state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, out_chan_q, out_chan_d, nxt;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [NUM_CH-1:0] mask_q, mask_d, scan_mask;
  logic out_valid_q, out_valid_d, done_q, done_d, found, idle;
  logic signed [SW:0] cur;
  assign idle = state_q == S_IDLE;
  assign scan_mask = idle ? bus.ch_mask : mask_q;
  assign cur = idle ? '1 : {1'b0, sel_q};
  mux_scan_next_ch #(.NUM_CH(NUM_CH), .SW(SW)) u_next (
    .mask(scan_mask),
    .cur(cur),
    .nxt(nxt),
    .found(found)
  );
  // sweep control: accept start in IDLE, capture after one settle cycle, advance on handshake
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    mask_d = mask_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    done_d = 1'b0;
    if (idle && bus.start) begin
      state_d = found ? S_SETTLE : S_IDLE;
      mask_d = found ? bus.ch_mask : mask_q;
      sel_d = found ? nxt : sel_q;
      done_d = !found;
    end else if (state_q == S_SETTLE) begin
      out_data_d = bus.mux_data;
      out_chan_d = sel_q;
      out_valid_d = 1'b1;
      state_d = S_OUT;
    end else if (state_q == S_OUT && out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d = found ? S_SETTLE : S_IDLE;
      sel_d = found ? nxt : '0;
      done_d = !found;
    end
  end
  // state and output registers, cleared immediately by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q <= '0;
      mask_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      mask_q <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      done_q <= done_d;
    end
  end
  assign bus.sel = sel_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_chan = out_chan_q;
  assign bus.busy = !idle;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mux_scan_seq.sv
// tb_mux_scan_seq: scoreboard bench for the mux scan sequencer
module tb_mux_scan_seq;
  import mux_scan_pkg::*;
  localparam int NC = 10;
  localparam int DW = 8;
  localparam int SW = 4;
  typedef struct packed {logic [DW-1:0] d; logic [SW-1:0] c;} smp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mux_scan_seq_if #(.NUM_CH(NC), .DW(DW), .SW(SW)) bus ();
  mux_scan_seq #(.NUM_CH(NC), .DW(DW), .SW(SW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [DW-1:0] vals [16];
  assign bus.mux_data = vals[bus.sel];
  smp_t q[$];
  int total = 0;
  int bad = 0;
  bit done_due = 1'b0;
  logic [NC-1:0] mask_m = '0;
  int bp_ch = -1;
  int bp_len = 0;
  int hold = 0;
  bit rnd_rdy = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // monitor: done timing, select legality and sample order against the queue
  initial forever begin
    @(negedge clk);
    chk("done", bus.done, done_due);
    done_due = 1'b0;
    if (bus.busy) chk("sel_in_mask", mask_m[bus.sel], 1);
    if (bus.out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_sample actual=%0h/%0d required=none", bus.out_data, bus.out_chan);
      end else begin
        chk("out_data", bus.out_data, q[0].d);
        chk("out_chan", bus.out_chan, q[0].c);
        if (bus.out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) done_due = 1'b1;
        end
      end
    end
  end
  // consumer: ready always, random, or stalled on a chosen channel
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_ch >= 0 && bus.out_valid && int'(bus.out_chan) == bp_ch && hold < bp_len) begin
        bus.out_ready = 1'b0;
        hold++;
      end else bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  task automatic load_start(input logic [NC-1:0] m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ch_mask = m;
    mask_m = m;
    for (int i = 0; i < NC; i++) if (m[i]) q.push_back('{d: vals[i], c: SW'(i)});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ch_mask = NC'($urandom);
    if (m == 0) done_due = 1'b1;
  endtask
  task automatic sweep(input logic [NC-1:0] m, input bit mid);
    int n;
    hold = 0;
    load_start(m);
    @(negedge clk);
    chk("busy_after_start", bus.busy, m != 0);
    chk("valid_after_start", bus.out_valid, 0);
    if (m != 0) begin
      @(negedge clk);
      chk("first_valid", bus.out_valid, 1);
    end
    n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
      if (mid && n == 3 && bus.busy) begin
        bus.start = 1'b1;
        bus.ch_mask = NC'(1);
      end else if (n == 4) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout actual=no_done required=done");
    end
    chk("queue_drained", q.size(), 0);
    chk("idle_after_done", bus.busy, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
  initial begin
    int n;
    logic [NC-1:0] m;
    bus.start = 1'b0;
    bus.ch_mask = '0;
    for (int i = 0; i < 16; i++) vals[i] = 8'hA0 + 8'(i);
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_chan", bus.out_chan, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    sweep('1, 1'b0);
    sweep(10'b10_0010_0100, 1'b0);
    bp_ch = 3;
    bp_len = 5;
    sweep('1, 1'b0);
    chk("bp_hold_cycles", hold, 5);
    bp_ch = -1;
    sweep('0, 1'b0);
    chk("empty_no_valid", bus.out_valid, 0);
    sweep('1, 1'b1);
    for (int i = 0; i < 16; i++) vals[i] = 8'($urandom);
    bp_ch = 4;
    bp_len = 100000;
    hold = 0;
    load_start('1);
    n = 0;
    while (!(bus.out_valid && bus.out_chan == 4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_chan4", bus.out_chan, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_data", bus.out_data, 0);
    chk("arst_chan", bus.out_chan, 0);
    chk("arst_sel", bus.sel, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    q.delete();
    done_due = 1'b0;
    bp_ch = -1;
    mask_m = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sweep(10'b11_0101_0000, 1'b0);
    rnd_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 16; i++) vals[i] = 8'($urandom);
      m = ($urandom_range(0, 5) == 0) ? '0 : NC'($urandom);
      sweep(m, $urandom_range(0, 2) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
